// File: rtl/ram_burst_ctrl_if.sv
// Host-side command / write-stream / read-stream bundle for ram_burst_ctrl.
// master = host side, slave = burst controller.
interface ram_burst_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, err
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, err
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a synchronous RAM with a one-cycle registered read.
// Optional RAMCTRL_WRAP_ERR_EN: reject bursts that would wrap past the top address.
module ram_burst_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_burst_ctrl_if.slave     bus,
    output logic                ram_cs,
    output logic                ram_rw,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_rw_q, ram_rw_d;
    logic                rd_valid_q, rd_valid_d;
    logic                cmd_acc, beat_acc, wrap_rej;
    logic                cmd_ready_c, wr_ready_c, done_c;

    assign cmd_acc  = bus.cmd_valid && (state_q == IDLE);
    assign beat_acc = bus.wr_valid && (state_q == WRITE);

`ifdef RAMCTRL_WRAP_ERR_EN
    logic err_q, err_d;

    assign wrap_rej = ({1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len}) > {1'b0, {ADDR_W{1'b1}}};
    assign err_d    = cmd_acc && wrap_rej;
    assign bus.err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    assign wrap_rej = 1'b0;
    assign bus.err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_ptr_q <= '0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_cs_q   <= 1'b0;
            ram_rw_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_ptr_q <= addr_ptr_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_cs_q   <= ram_cs_d;
            ram_rw_q   <= ram_rw_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // DRAIN holds while the last registered RAM access is still in flight, so
    // it ends only once the final write has landed or the final read returned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_acc && !wrap_rej) state_d = bus.cmd_rw ? WRITE : READ;
            WRITE:   if (beat_acc && (cnt_q == '0)) state_d = DRAIN;
            READ:    if (cnt_q == '0) state_d = DRAIN;
            DRAIN:   if (!ram_cs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_ptr_d  = addr_ptr_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_cs_d    = 1'b0;
        ram_rw_d    = ram_rw_q;
        rd_valid_d  = ram_cs_q && !ram_rw_q;
        cmd_ready_c = (state_q == IDLE);
        wr_ready_c  = (state_q == WRITE);
        // Write done: last write on the RAM pins; read done: last byte back.
        done_c      = (state_q == DRAIN) &&
                      ((ram_cs_q && ram_rw_q) || (rd_valid_q && !ram_cs_q));
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    addr_ptr_d = bus.cmd_addr;
                    cnt_d      = bus.cmd_len;
                end
            end
            WRITE: begin
                if (beat_acc) begin
                    ram_cs_d   = 1'b1;
                    ram_rw_d   = 1'b1;
                    ram_addr_d = addr_ptr_q;
                    ram_din_d  = bus.wr_data;
                    addr_ptr_d = addr_ptr_q + ADDR_W'(1);
                    cnt_d      = cnt_q - ADDR_W'(1);
                end
            end
            READ: begin
                ram_cs_d   = 1'b1;
                ram_rw_d   = 1'b0;
                ram_addr_d = addr_ptr_q;
                addr_ptr_d = addr_ptr_q + ADDR_W'(1);
                cnt_d      = cnt_q - ADDR_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.wr_ready  = wr_ready_c;
    assign bus.done      = done_c;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = ram_dout;
    assign ram_cs        = ram_cs_q;
    assign ram_rw        = ram_rw_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 64x8 RAM and a read-data scoreboard.
module tb_ram_burst_ctrl;
    logic       clk;
    logic       rst_n;
    logic       ram_cs, ram_rw;
    logic [5:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    ram_burst_ctrl_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    ram_burst_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_cs   (ram_cs),
        .ram_rw   (ram_rw),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    logic [7:0] ram_mem   [0:63];
    logic [7:0] model_mem [0:63];
    logic [7:0] sb[$];
    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rw) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            chk("rd_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) chk("rd_data", bus.rd_data, sb.pop_front());
        end
    end

    task automatic do_write(input logic [5:0] a, input int n, input logic [7:0] base,
                            input int stall_at, input int stall_cyc);
        int b = 0;
        logic [5:0] ea;
        logic [7:0] ed;
        chk("w_cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b1;
        bus.cmd_addr = a; bus.cmd_len = 6'(n - 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("w_cmd_ready_busy", bus.cmd_ready, 0);
        for (int t = 0; b < n; t++) begin
            logic v;
            v  = !(t >= stall_at && t < stall_at + stall_cyc);
            ea = a + 6'(b);
            ed = base + 8'(b);
            chk("w_wr_ready", bus.wr_ready, 1);
            bus.wr_valid = v;
            bus.wr_data  = ed;
            if (v) model_mem[ea] = ed;
            @(negedge clk);
            chk("w_ram_cs", ram_cs, v);
            chk("w_done", bus.done, v && (b == n - 1));
            if (v) begin
                chk("w_ram_addr", ram_addr, ea);
                chk("w_ram_din", ram_din, ed);
                chk("w_ram_rw", ram_rw, 1);
                b++;
            end
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("w_drain_done", bus.done, 0);
        chk("w_drain_cs", ram_cs, 0);
        chk("w_drain_ready", bus.cmd_ready, 0);
        @(negedge clk);
        chk("w_back_idle", bus.cmd_ready, 1);
    endtask

    task automatic do_read(input logic [5:0] a, input int n);
        logic [5:0] ea;
        chk("r_cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0;
        bus.cmd_addr = a; bus.cmd_len = 6'(n - 1);
        for (int i = 0; i < n; i++) begin
            ea = a + 6'(i);
            sb.push_back(model_mem[ea]);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("r_c0_cs", ram_cs, 0);
        chk("r_c0_valid", bus.rd_valid, 0);
        for (int t = 1; t <= n + 1; t++) begin
            @(negedge clk);
            ea = a + 6'(t - 1);
            chk("r_ram_cs", ram_cs, t <= n);
            if (t <= n) begin
                chk("r_ram_addr", ram_addr, ea);
                chk("r_ram_rw", ram_rw, 0);
            end
            chk("r_rd_valid", bus.rd_valid, t >= 2);
            chk("r_done", bus.done, t == n + 1);
            chk("r_cmd_ready_busy", bus.cmd_ready, 0);
        end
        @(negedge clk);
        chk("r_back_idle", bus.cmd_ready, 1);
        chk("r_idle_valid", bus.rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i]   = 8'h00;
            model_mem[i] = 8'h00;
        end
        ram_dout      = 8'h00;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0;
        bus.cmd_addr  = '0;   bus.cmd_len = '0;
        bus.wr_valid  = 1'b0; bus.wr_data = '0;
        #12;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_rw", ram_rw, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then back-to-back readback
        do_write(6'd5, 4, 8'hA1, 0, 0);
        do_read(6'd5, 4);

        // Two-cycle write bubble after the first beat
        do_write(6'd10, 3, 8'h30, 1, 2);
        do_read(6'd10, 3);

        // Burst crossing the top of the address space
`ifdef RAMCTRL_WRAP_ERR_EN
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b1;
        bus.cmd_addr = 6'd62; bus.cmd_len = 6'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("wrap_err_pulse", bus.err, 1);
        chk("wrap_err_ready", bus.cmd_ready, 1);
        chk("wrap_err_cs", ram_cs, 0);
        @(negedge clk);
        chk("wrap_err_clear", bus.err, 0);
        chk("wrap_err_cs2", ram_cs, 0);
        chk("wrap_err_ready2", bus.cmd_ready, 1);
`else
        do_write(6'd62, 4, 8'hC0, 0, 0);
        chk("wrap_mem62", ram_mem[62], 8'hC0);
        chk("wrap_mem63", ram_mem[63], 8'hC1);
        chk("wrap_mem0", ram_mem[0], 8'hC2);
        chk("wrap_mem1", ram_mem[1], 8'hC3);
        chk("wrap_no_err", bus.err, 0);
        do_read(6'd62, 4);
`endif

        // Single-byte read at the last address
        do_read(6'd63, 1);

        // Reset in the second cycle of a 10-byte read
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0;
        bus.cmd_addr = 6'd0; bus.cmd_len = 6'd9;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_cs_before", ram_cs, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rd_valid", bus.rd_valid, 0);
        chk("rstmid_ram_cs", ram_cs, 0);
        chk("rstmid_cmd_ready", bus.cmd_ready, 1);
        chk("rstmid_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid_quiet", bus.rd_valid, 0);
        do_read(6'd5, 4);

        // cmd_valid held through a read burst; stray wr_valid is ignored
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0;
        bus.cmd_addr = 6'd5; bus.cmd_len = 6'd1;
        sb.push_back(model_mem[5]);
        sb.push_back(model_mem[6]);
        @(negedge clk);
        bus.cmd_rw = 1'b1; bus.cmd_addr = 6'd20; bus.cmd_len = 6'd0;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h77;
        model_mem[20] = 8'h77;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_wr_ready", bus.wr_ready, 0);
            chk("hold_no_write", ram_cs && ram_rw, 0);
        end
        @(negedge clk);
        chk("hold_ready_back", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("hold_accepted", bus.wr_ready, 1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("hold_w_cs", ram_cs, 1);
        chk("hold_w_rw", ram_rw, 1);
        chk("hold_w_addr", ram_addr, 6'd20);
        chk("hold_w_din", ram_din, 8'h77);
        chk("hold_w_done", bus.done, 1);
        @(negedge clk);
        chk("hold_w_done_clr", bus.done, 0);
        @(negedge clk);
        chk("hold_w_idle", bus.cmd_ready, 1);
        do_read(6'd20, 1);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
